// File: rtl/reg_writeback_queue.sv
// Purpose: in-order register-file writeback queue with read-port forwarding.
// Latency: an accepted write reaches the RW/PW_DS/E write port one cycle later at the earliest.
// Backpressure: In_Ready drops only when full and not draining; Hold stalls the drain, never acceptance.
// Ports: Clk, Reset (synchronous, active-high)
//        In_Valid/In_RW/In_Data/In_Ready : producer handshake (In_RW=0 is consumed and dropped)
//        Hold, E/RW/PW_DS                : register-file write port
//        RA/RB -> Fwd_{A,B}_Hit/_Data    : youngest pending write to each read address
//        Count                           : number of queued entries
module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     In_Valid,
   input  logic [4:0]               In_RW,
   input  logic [31:0]              In_Data,
   output logic                     In_Ready,
   input  logic                     Hold,
   output logic [31:0]              PW_DS,
   output logic [4:0]               RW,
   output logic                     E,
   input  logic [4:0]               RA,
   input  logic [4:0]               RB,
   output logic                     Fwd_A_Hit,
   output logic                     Fwd_B_Hit,
   output logic [31:0]              Fwd_A_Data,
   output logic [31:0]              Fwd_B_Data,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef struct packed {
      logic [4:0]  rw;
      logic [31:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [AW-1:0] fwd_idx;
   logic          not_empty;
   logic          pop;
   logic          push;

   assign not_empty = (cnt != '0);

   // Every output is forced to its idle value while Reset is high, so the
   // queue looks empty during the reset cycle itself, not only after it.
   assign pop      = !Reset && not_empty && !Hold;
   assign E        = pop;
   assign In_Ready = Reset || (cnt < FULL) || pop;
   // Writes to r0 complete the handshake but are never stored.
   assign push     = !Reset && In_Valid && In_Ready && (In_RW != 5'd0);

   assign Count = Reset ? '0 : cnt;
   assign RW    = (!Reset && not_empty) ? mem[rd_ptr].rw   : 5'd0;
   assign PW_DS = (!Reset && not_empty) ? mem[rd_ptr].data : 32'd0;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Storage is not reset; occupancy alone decides which slots are live.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= '{rw: In_RW, data: In_Data};
      end
   end

   // Walk live entries oldest to youngest so the last match wins. DEPTH is
   // a power of two, so the AW-bit add wraps the index around the ring.
   // The head is included even while it is being popped this cycle.
   always_comb begin
      Fwd_A_Hit  = 1'b0;
      Fwd_A_Data = 32'd0;
      Fwd_B_Hit  = 1'b0;
      Fwd_B_Data = 32'd0;
      fwd_idx    = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + AW'(i);
         if (!Reset && (CW'(i) < cnt)) begin
            if ((RA != 5'd0) && (mem[fwd_idx].rw == RA)) begin
               Fwd_A_Hit  = 1'b1;
               Fwd_A_Data = mem[fwd_idx].data;
            end
            if ((RB != 5'd0) && (mem[fwd_idx].rw == RB)) begin
               Fwd_B_Hit  = 1'b1;
               Fwd_B_Data = mem[fwd_idx].data;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Purpose: self-checking bench for reg_writeback_queue (DEPTH=4).
// Latency: checks outputs mid-cycle against a queue-based model and hand-built vectors.
// Backpressure: exercises full/stall, Hold, r0 drop, pointer wrap, reset and random traffic.
module tb_reg_writeback_queue;

   localparam int DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        In_Valid;
   logic [4:0]  In_RW;
   logic [31:0] In_Data;
   logic        In_Ready;
   logic        Hold;
   logic [31:0] PW_DS;
   logic [4:0]  RW;
   logic        E;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic        Fwd_A_Hit;
   logic        Fwd_B_Hit;
   logic [31:0] Fwd_A_Data;
   logic [31:0] Fwd_B_Data;
   logic [2:0]  Count;

   reg_writeback_queue #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset),
      .In_Valid(In_Valid), .In_RW(In_RW), .In_Data(In_Data), .In_Ready(In_Ready),
      .Hold(Hold), .PW_DS(PW_DS), .RW(RW), .E(E),
      .RA(RA), .RB(RB),
      .Fwd_A_Hit(Fwd_A_Hit), .Fwd_B_Hit(Fwd_B_Hit),
      .Fwd_A_Data(Fwd_A_Data), .Fwd_B_Data(Fwd_B_Data),
      .Count(Count)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [4:0]  rw;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [4:0]  irw;
      logic [31:0] idat;
      logic        hold;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        e;
      logic [4:0]  orw;
      logic [31:0] odat;
      logic [2:0]  cnt;
      logic        rdy;
      logic        ha;
      logic [31:0] da;
      logic        hb;
      logic [31:0] db;
   } tv_t;

   tv_t  tab[$];
   tv_t  nt;
   ent_t mq[$];    // reference model: pending writes, oldest first
   ent_t obs[$];   // writes seen on the register-file port
   int   n_vec  = 0;
   int   n_miss = 0;
   int   maxc   = 0;

   logic        m_e, m_rdy, m_ha, m_hb;
   logic [4:0]  m_rw;
   logic [31:0] m_d, m_da, m_db;
   int          m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tv(input logic rst, input logic vld, input logic [4:0] irw,
                     input logic [31:0] idat, input logic hold, input logic [4:0] ra,
                     input logic [4:0] rb, input logic e, input logic [4:0] orw,
                     input logic [31:0] odat, input logic [2:0] cnt, input logic rdy,
                     input logic ha, input logic [31:0] da, input logic hb,
                     input logic [31:0] db);
      tv_t t;
      t = '{rst, vld, irw, idat, hold, ra, rb, e, orw, odat, cnt, rdy, ha, da, hb, db};
      tab.push_back(t);
   endtask

   // Expected outputs from the pending-write list and current inputs.
   task automatic model_outputs();
      m_e   = !Reset && (mq.size() != 0) && !Hold;
      m_cnt = Reset ? 0 : mq.size();
      m_rdy = Reset || (mq.size() < DEPTH) || m_e;
      m_rw = 0; m_d = 0; m_ha = 0; m_da = 0; m_hb = 0; m_db = 0;
      if (!Reset) begin
         if (mq.size() != 0) begin
            m_rw = mq[0].rw;
            m_d  = mq[0].data;
         end
         foreach (mq[i]) begin
            if (RA != 0 && mq[i].rw == RA) begin m_ha = 1; m_da = mq[i].data; end
            if (RB != 0 && mq[i].rw == RB) begin m_hb = 1; m_db = mq[i].data; end
         end
      end
   endtask

   function automatic bit model_accepts();
      return !Reset && In_Valid &&
             ((mq.size() < DEPTH) || ((mq.size() != 0) && !Hold));
   endfunction

   task automatic model_commit();
      bit pop, acc;
      if (Reset) begin
         mq.delete();
      end else begin
         pop = (mq.size() != 0) && !Hold;
         acc = In_Valid && (In_RW != 0) && ((mq.size() < DEPTH) || pop);
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back('{In_RW, In_Data});
      end
   endtask

   // One clock: compare mid-cycle, then advance the model on the rising edge.
   task automatic step(input bit use_t, input tv_t t);
      @(negedge Clk);
      model_outputs();
      chk("E",        E,          m_e);
      chk("RW",       RW,         m_rw);
      chk("PW_DS",    PW_DS,      m_d);
      chk("Count",    Count,      m_cnt);
      chk("In_Ready", In_Ready,   m_rdy);
      chk("FwdA_hit", Fwd_A_Hit,  m_ha);
      chk("FwdA_dat", Fwd_A_Data, m_da);
      chk("FwdB_hit", Fwd_B_Hit,  m_hb);
      chk("FwdB_dat", Fwd_B_Data, m_db);
      if (use_t) begin
         chk("tv_E",        E,          t.e);
         chk("tv_RW",       RW,         t.orw);
         chk("tv_PW_DS",    PW_DS,      t.odat);
         chk("tv_Count",    Count,      t.cnt);
         chk("tv_In_Ready", In_Ready,   t.rdy);
         chk("tv_FwdA_hit", Fwd_A_Hit,  t.ha);
         chk("tv_FwdA_dat", Fwd_A_Data, t.da);
         chk("tv_FwdB_hit", Fwd_B_Hit,  t.hb);
         chk("tv_FwdB_dat", Fwd_B_Data, t.db);
      end
      if (E === 1'b1) obs.push_back('{RW, PW_DS});
      if (int'(Count) > maxc) maxc = int'(Count);
      @(posedge Clk);
      model_commit();
      #1;
   endtask

   task automatic drive(input logic rst, input logic vld, input logic [4:0] rw,
                        input logic [31:0] dat, input logic hold);
      Reset = rst; In_Valid = vld; In_RW = rw; In_Data = dat; Hold = hold;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int r;
      int cyc;

      // Hold-then-drain with forwarding, then reset with three pending and a push.
      tv(1,0,0,0,        0,5,9, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,1,5,32'h11,   1,5,9, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,1,5,32'h22,   1,5,9, 0,5,32'h11,  1,1, 1,32'h11,  0,0);
      tv(0,1,9,32'h33,   1,5,9, 0,5,32'h11,  2,1, 1,32'h22,  0,0);
      tv(0,0,0,0,        1,5,9, 0,5,32'h11,  3,1, 1,32'h22,  1,32'h33);
      tv(0,0,0,0,        0,5,9, 1,5,32'h11,  3,1, 1,32'h22,  1,32'h33);
      tv(0,0,0,0,        0,5,9, 1,5,32'h22,  2,1, 1,32'h22,  1,32'h33);
      tv(0,0,0,0,        0,5,9, 1,9,32'h33,  1,1, 0,0,       1,32'h33);
      tv(0,0,0,0,        0,5,9, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,1,3,32'h1,    1,3,4, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,1,4,32'h2,    1,3,4, 0,3,32'h1,   1,1, 1,32'h1,   0,0);
      tv(0,1,3,32'h3,    1,3,4, 0,3,32'h1,   2,1, 1,32'h1,   1,32'h2);
      tv(1,1,6,32'h4,    0,3,4, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,0,0,0,        0,3,4, 0,0,0,       0,1, 0,0,       0,0);
      tv(0,0,0,0,        0,3,4, 0,0,0,       0,1, 0,0,       0,0);

      drive(1, 0, 0, 0, 0); RA = 0; RB = 0;
      @(posedge Clk); #1;
      model_commit();

      for (int i = 0; i < tab.size(); i++) begin
         drive(tab[i].rst, tab[i].vld, tab[i].irw, tab[i].idat, tab[i].hold);
         RA = tab[i].ra; RB = tab[i].rb;
         step(1, tab[i]);
      end

      // Full queue stalls the offer; releasing Hold pushes and pops together.
      RA = 7; RB = 1;
      for (int i = 1; i <= DEPTH; i++) begin
         drive(0, 1, 5'(i), 32'(i * 16), 1);
         step(0, nt);
      end
      drive(0, 1, 7, 32'hAA, 1);
      #1;
      chk("full_ready_low", In_Ready, 0);
      chk("full_count",     Count,    DEPTH);
      step(0, nt);
      step(0, nt);
      obs.delete();
      Hold = 0;
      #1;
      chk("release_ready", In_Ready, 1);
      chk("release_E",     E,        1);
      step(0, nt);
      In_Valid = 0;
      #1;
      chk("pushpop_count", Count, DEPTH);
      for (int i = 0; i < 6; i++) step(0, nt);
      chk("full_drain_n", obs.size(), 5);
      if (obs.size() == 5) begin
         for (int i = 0; i < 4; i++) begin
            chk("full_drain_rw",  obs[i].rw,   i + 1);
            chk("full_drain_dat", obs[i].data, (i + 1) * 16);
         end
         chk("last_rw",  obs[4].rw,   7);
         chk("last_dat", obs[4].data, 32'hAA);
      end

      // Writes to r0 are consumed but leave no trace.
      obs.delete();
      RA = 0;
      drive(0, 1, 0, 32'hDEAD, 0);
      #1;
      chk("r0_ready",  In_Ready,  1);
      chk("r0_fwd",    Fwd_A_Hit, 0);
      step(0, nt);
      In_Valid = 0;
      #1;
      chk("r0_count", Count, 0);
      for (int i = 0; i < 3; i++) step(0, nt);
      chk("r0_no_write", obs.size(), 0);

      // Ten writes across the ring with Hold toggling every three cycles.
      obs.delete();
      maxc = 0;
      RA = 3; RB = 10;
      r = 1;
      cyc = 0;
      while (r <= 10 && cyc < 200) begin
         drive(0, 1, 5'(r), 32'(r * 256), ((cyc / 3) % 2) == 1);
         acc = model_accepts();
         step(0, nt);
         if (acc) r++;
         cyc++;
      end
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, nt);
      chk("wrap_n", obs.size(), 10);
      if (obs.size() == 10) begin
         for (int i = 0; i < 10; i++) begin
            chk("wrap_rw",  obs[i].rw,   i + 1);
            chk("wrap_dat", obs[i].data, (i + 1) * 256);
         end
      end
      chk("wrap_max_count_ok", maxc <= DEPTH, 1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
         RA = 5'($urandom_range(0, 7));
         RB = 5'($urandom_range(0, 7));
         step(0, nt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning the number of queued register writes (power of two, 2..16).
REQ-002 Clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Reset  input  1  reset; the single clock is Clk and Reset SHALL be synchronous and active-high.
REQ-004 In_Valid  input  1  the producer (ALU/load writeback) offers a register write.
REQ-005 In_RW  input  5  destination register number of the offered write.
REQ-006 In_Data  input  32  data of the offered write.
REQ-007 In_Ready  output  1  the queue accepts the offer this cycle.
REQ-008 Hold  input  1  the register-file write port is unavailable; the queue SHALL not drain.
REQ-009 PW_DS  output  32  write data to the register file.
REQ-010 RW  output  5  write register number to the register file.
REQ-011 E  output  1  write enable to the register file.
REQ-012 RA / RB  input  5 each  read addresses currently presented to the register file.
REQ-013 Fwd_A_Hit / Fwd_B_Hit  output  1 each  a queued write to RA / RB is pending.
REQ-014 Fwd_A_Data / Fwd_B_Data  output  32 each  data of the youngest pending write to RA / RB.
REQ-015 Count  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-016 Storage: circular buffer of DEPTH entries {rw[4:0], data[31:0]}, write pointer, read pointer, occupancy counter 0..DEPTH.
REQ-017 Accept: push occurs when In_Valid=1, In_Ready=1 and In_RW!=0; entry is written at the write pointer, the pointer wraps from DEPTH-1 to 0.
REQ-018 Register 0: In_Valid=1 with In_RW=0 SHALL be consumed (handshake completes) but SHALL NOT be queued, counted, or forwarded.
REQ-019 Drain: E = (Count!=0) and Hold=0, combinational; PW_DS/RW SHALL present the head entry; when E=1 the head is popped at the clock edge and the read pointer wraps from DEPTH-1 to 0.
REQ-020 PW_DS and RW SHALL be 0 when Count=0.
REQ-021 In_Ready = (Count<DEPTH) or E; a push and a pop in the same cycle SHALL both occur, including when full, leaving Count unchanged.
REQ-022 Count: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH, never underflows.
REQ-023 Latency: an entry accepted at edge N SHALL be presented on RW/PW_DS with E=1 no earlier than cycle N+1, i.e. queued data is never bypassed straight to the write port in the accepting cycle.
REQ-024 Ordering: entries SHALL reach the register file in acceptance order; entries with the same RW SHALL NOT be merged.
REQ-025 Forwarding: Fwd_X_Hit=1 when any queued entry (head included, even while it is being popped) has rw==RX and RX!=0; Fwd_X_Data SHALL equal the youngest such entry's data; Hit=0 and Data=0 otherwise; purely combinational from queue state, RX and nothing else.
REQ-026 An offer on In_* in the current cycle SHALL NOT affect forwarding outputs until it is queued.
REQ-027 Hold SHALL block only draining; acceptance continues while Count<DEPTH.

Reset
REQ-028 Reset=1 at a rising edge SHALL clear both pointers and Count to 0, discarding pending entries, including mid-drain or mid-push; a push or pop offered in that cycle SHALL be ignored.
REQ-029 While Reset=1 and after it: E=0, PW_DS=0, RW=0, Count=0, In_Ready=1, all Fwd outputs 0; entry storage need not be cleared.

Verification
REQ-030 Hold=1, push (5,0x11),(5,0x22),(9,0x33) -> Count=3, E=0; RA=5 gives Fwd_A_Hit=1, Fwd_A_Data=0x22; RB=9 gives 0x33.
REQ-031 Continue: Hold=0 -> E=1 for three consecutive cycles with (RW,PW_DS)=(5,0x11),(5,0x22),(9,0x33), then E=0, Count=0, Fwd hits 0.
REQ-032 Hold=1, fill with DEPTH=4 entries -> In_Ready=0, fifth offer stalls; release Hold with offer (7,0xAA) held -> push and pop same cycle, Count stays 4, (7,0xAA) drains last.
REQ-033 Offer In_RW=0, In_Data=0xDEAD -> In_Ready=1, Count unchanged, E never asserts for it; RA=0 -> Fwd_A_Hit=0.
REQ-034 Wrap: 10 pushes of (r, r*0x100) for r=1..10 with Hold toggling every 3 cycles -> all ten writes reach the register file in order, Count never exceeds 4.
REQ-035 Reset asserted with Count=3 and a concurrent push -> next cycle Count=0, E=0, In_Ready=1, no stale entry drains afterwards.
